// File: rtl/octave_keypoint_collector_pkg.sv
// Shared definitions for the keypoint collector.
// Record layout, MSB first: {eof, lane[1:0], sign, y[9:0], x[9:0], mag[outW-1:0]}.
// The field positions below are offsets above the mag field. The absolute
// bit position of a field is outW plus its offset.
package sift_kp_pkg;
  localparam int KP_XY_W     = 10;
  localparam int KP_LANE_W   = 2;
  localparam int KP_X_LSB    = 0;
  localparam int KP_Y_LSB    = 10;
  localparam int KP_SIGN_BIT = 20;
  localparam int KP_LANE_LSB = 21;
  localparam int KP_EOF_BIT  = 23;

  // Total record width for a given lane sample width.
  function automatic int kp_w(input int outW);
    return 24 + outW;
  endfunction

  // |v| clamped to the largest positive w-bit value, so the most negative
  // input maps to 2^(w-1)-1 and does not wrap. Valid for w up to 15.
  function automatic logic [15:0] sat_abs(input logic signed [15:0] v, input int w);
    logic [15:0] lim, a;
    lim = 16'((32'd1 << (w - 1)) - 32'd1);
    a   = (v < 0) ? 16'(-v) : 16'(v);
    return (a > lim) ? lim : a;
  endfunction
endpackage

// File: rtl/octave_keypoint_collector_if.sv
// Keypoint record stream, valid/ready.
//   master: drives kp_valid and kp_data; samples kp_ready
//   slave : samples kp_valid and kp_data; drives kp_ready
interface octave_keypoint_collector_if #(parameter int W = 32);
  logic         kp_valid;
  logic         kp_ready;
  logic [W-1:0] kp_data;
  modport master(output kp_valid, output kp_data, input kp_ready);
  modport slave (input kp_valid, input kp_data, output kp_ready);
endinterface

// File: rtl/octave_keypoint_collector_fifo.sv
// kp_fifo: synchronous FIFO with a registered head word.
//   clk, rst_p      clock, async active-high reset (empties FIFO, clears dout)
//   push, wdata     write; ignored when full unless a pop happens in the same cycle
//   pop             read; only meaningful while valid
//   dout, valid     head word and its valid flag
//   full            all D entries occupied
// dout always holds the head entry, so it stays stable until a pop. A write
// into an empty FIFO lands in dout at the same edge, giving one cycle from
// push to valid.
module kp_fifo #(
  parameter int W = 32,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst_p,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] rd, wr, rdNext;
  logic [AW:0]   cnt;
  logic          wrEn, rdEn;

  assign valid  = (cnt != '0);
  assign full   = (cnt == (AW+1)'(D));
  assign rdEn   = pop && valid;
  // The slot freed by a pop is available to a push in the same cycle.
  assign wrEn   = push && (!full || rdEn);
  assign rdNext = rd + 1'b1;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      if (wrEn) wr <= wr + 1'b1;
      if (rdEn) rd <= rdNext;
      case ({wrEn, rdEn})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // With one entry left, the next head can only be the word being
      // written now, because it is not in mem yet.
      if (rdEn)
        dout <= (cnt == (AW+1)'(1)) ? wdata : mem[rdNext];
      else if (!valid && wrEn)
        dout <= wdata;
    end
  end
endmodule

// File: rtl/octave_keypoint_collector.sv
// octave_keypoint_collector: thresholds the octave datapath lane outputs and
// packs the qualifying samples into keypoint records.
//   clk, rst_p    clock, async active-high reset
//   en, sof       sample strobe and frame start (datapath input pixel 0)
//   laneIn        laneN signed outW-bit lanes, lane i at [i*outW +: outW]
//   thr           unsigned magnitude threshold (strictly greater qualifies)
//   kp            record stream (master): {eof, lane, sign, y, x, mag}
//   ovf_cnt       saturating count of dropped records
// Optional macro KP_NMS_EN selects 1-D horizontal non-max suppression.
module octave_keypoint_collector
  import sift_kp_pkg::*;
#(
  parameter int outW     = 8,
  parameter int laneN    = 4,
  parameter int frameW   = 640,
  parameter int frameH   = 480,
  parameter int PIPE_LAT = 200,
  parameter int FIFO_D   = 16
) (
  input  logic                    clk,
  input  logic                    rst_p,
  input  logic                    en,
  input  logic                    sof,
  input  logic [outW*laneN-1:0]   laneIn,
  input  logic [outW-1:0]         thr,
  octave_keypoint_collector_if.master kp,
  output logic [15:0]             ovf_cnt
);
  localparam int RW = kp_w(outW);
  localparam logic [RW-1:0] EOF_REC = RW'(1) << (outW + KP_EOF_BIT);

  // Scoring: saturated magnitude per lane, then the largest, lowest index on ties.
  logic [laneN-1:0][outW-1:0] mag;
  logic [outW-1:0]            bestMag;
  logic [KP_LANE_W-1:0]       bestLane;
  logic                       sign;

  for (genvar gi = 0; gi < laneN; gi++) begin : gLane
    assign mag[gi] = outW'(sat_abs(16'(signed'(laneIn[gi*outW +: outW])), outW));
  end

  always_comb begin
    bestMag  = mag[0];
    bestLane = '0;
    for (int i = 1; i < laneN; i++) begin
      if (mag[i] > bestMag) begin
        bestMag  = mag[i];
        bestLane = KP_LANE_W'(i);
      end
    end
  end
  assign sign = laneIn[int'(bestLane)*outW + outW - 1];

  // Latency compensation and pixel coordinates. A sof takes effect in its
  // own cycle, so a sof sample with en is already the first warm-up sample.
  logic [15:0]         wcnt, wc;
  logic                active, act, pix, lastPix;
  logic [KP_XY_W-1:0]  x, y, xc, yc;
  logic [RW-1:0]       curRec;

  always_comb begin
    wc      = sof ? 16'(PIPE_LAT) : wcnt;
    act     = sof | active;
    xc      = sof ? '0 : x;
    yc      = sof ? '0 : y;
    pix     = en && (wc == '0) && act;
    lastPix = pix && (xc == KP_XY_W'(frameW-1)) && (yc == KP_XY_W'(frameH-1));
  end
  assign curRec = {1'b0, bestLane, sign, yc, xc, bestMag};

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      wcnt   <= '0;
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (sof || en) begin
      wcnt   <= (en && wc != '0) ? wc - 16'd1 : wc;
      active <= act && !lastPix;
      if (pix && xc == KP_XY_W'(frameW-1)) begin
        x <= '0;
        y <= yc + 1'b1;
      end else begin
        x <= pix ? xc + 1'b1 : xc;
        y <= yc;
      end
    end
  end

  // Registered stage feeding the FIFO. sLast marks the frame's final pixel.
  logic          sVld, sLast;
  logic [RW-1:0] sRec;

`ifdef KP_NMS_EN
  // A candidate waits one pixel for its right neighbour. A line-end
  // candidate compares against 0 on the right. A frame-end candidate is
  // decided the following cycle. A sof discards a pending mid-frame candidate.
  logic            cV, cLineEnd, cFrameEnd, decide, keep;
  logic [RW-1:0]   cRec;
  logic [outW-1:0] cScore, cLeft, right;

  assign decide = cV && (cFrameEnd || (en && !sof));
  assign right  = (cLineEnd || !pix) ? '0 : bestMag;
  assign keep   = (cScore > cLeft) && (cScore >= right) && (cScore > thr);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      cV <= 1'b0; cLineEnd <= 1'b0; cFrameEnd <= 1'b0;
      cRec <= '0; cScore <= '0; cLeft <= '0;
      sVld <= 1'b0; sLast <= 1'b0; sRec <= '0;
    end else begin
      sVld  <= decide && keep;
      sLast <= decide && cFrameEnd;
      sRec  <= cRec;
      if (pix) begin
        cV        <= 1'b1;
        cRec      <= curRec;
        cScore    <= bestMag;
        cLeft     <= (xc == '0) ? '0 : cScore;
        cLineEnd  <= (xc == KP_XY_W'(frameW-1));
        cFrameEnd <= lastPix;
      end else if (decide || sof) begin
        cV <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sVld <= 1'b0; sLast <= 1'b0; sRec <= '0;
    end else begin
      sVld  <= pix && (bestMag > thr);
      sLast <= lastPix;
      sRec  <= curRec;
    end
  end
`endif

  // FIFO push arbitration. A pending EOF marker owns the write port until it
  // lands. Any keypoint in the stage meanwhile is dropped.
  logic          pop, full, space, eofPend, eofPush, kpPush, push, drop;
  logic [RW-1:0] wdata;

  assign pop     = kp.kp_valid && kp.kp_ready;
  assign space   = !full || pop;
  assign eofPush = eofPend && space;
  assign kpPush  = sVld && !eofPend && space;
  assign push    = eofPush || kpPush;
  assign wdata   = eofPush ? EOF_REC : sRec;
  assign drop    = sVld && (eofPend || !space);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      eofPend <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      eofPend <= (eofPend && !space) || sLast;
      if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  kp_fifo #(.W(RW), .D(FIFO_D)) uFifo (
    .clk   (clk),
    .rst_p (rst_p),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .dout  (kp.kp_data),
    .valid (kp.kp_valid),
    .full  (full)
  );
endmodule

// File: tb/tb_octave_keypoint_collector.sv
// Testbench for octave_keypoint_collector.
// Small frame: 8x2, PIPE_LAT=3, FIFO_D=16, outW=8, laneN=4.
module tb_octave_keypoint_collector;
  logic        clk = 1'b0;
  logic        rst_p, en, sof;
  logic [31:0] laneIn;
  logic [7:0]  thr;
  logic [15:0] ovf_cnt;
  int          nchk = 0, nerr = 0;

  octave_keypoint_collector_if #(.W(32)) kpIf();

  octave_keypoint_collector #(
    .outW(8), .laneN(4), .frameW(8), .frameH(2), .PIPE_LAT(3), .FIFO_D(16)
  ) dut (
    .clk(clk), .rst_p(rst_p), .en(en), .sof(sof), .laneIn(laneIn),
    .thr(thr), .kp(kpIf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          l0, l1, l2, l3;
    int          th;
    bit          v;
    logic [31:0] d;
  } vec_t;
  vec_t vt[7];

  function automatic logic [31:0] mkrec(bit e, int lane, bit s, int y, int x, int m);
    return {e, 2'(lane), s, 10'(y), 10'(x), 8'(m)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input bit s, input bit e, input int l0, input int l1,
                     input int l2, input int l3);
    @(posedge clk); #1;
    sof = s; en = e;
    laneIn = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endtask

  // Takes the head record: waits a bounded time for valid, then pops it.
  task automatic expect_rec(input string nm, input logic [31:0] exp);
    bit got;
    logic [31:0] d;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (kpIf.kp_valid) begin
        d = kpIf.kp_data;
        got = 1'b1;
      end
    end
    if (!got) begin
      nchk++; nerr++;
      $display("FAIL %s: no record within 100 cycles, expected %h", nm, exp);
    end else begin
      chk(nm, d, exp);
      kpIf.kp_ready = 1'b1;
      @(posedge clk); #1;
      kpIf.kp_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sof = 0; en = 0; laneIn = '0; kpIf.kp_ready = 1'b0;
    rst_p = 1'b1;
    #2 rst_p = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 20, 0, 0, 10, 1'b1, mkrec(0, 1, 0, 0, 0, 20)};
    vt[1] = '{-128, 127, 0, 0, 100, 1'b1, mkrec(0, 0, 1, 0, 0, 127)};
    vt[2] = '{5, -9, 3, 0, 10, 1'b0, 32'h0};
    vt[3] = '{0, 0, 0, -11, 10, 1'b1, mkrec(0, 3, 1, 0, 0, 11)};
    vt[4] = '{10, 10, 0, 0, 10, 1'b0, 32'h0};
    vt[5] = '{0, 0, 50, 50, 10, 1'b1, mkrec(0, 2, 0, 0, 0, 50)};
    vt[6] = '{-100, 0, 0, 100, 0, 1'b1, mkrec(0, 0, 1, 0, 0, 100)};

    rst_p = 1'b1; en = 0; sof = 0; laneIn = '0; thr = '0; kpIf.kp_ready = 1'b0;
    #7;
    chk("reset valid", 32'(kpIf.kp_valid), 0);
    chk("reset data", kpIf.kp_data, 0);
    chk("reset ovf", 32'(ovf_cnt), 0);
    #5 rst_p = 1'b0;

    // Single-pixel scoring vectors: pixel (0,0) after warm-up each time.
    for (int i = 0; i < 7; i++) begin
      thr = 8'(vt[i].th);
      put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
      put(0, 1, vt[i].l0, vt[i].l1, vt[i].l2, vt[i].l3);
      put(0, 0, 0, 0, 0, 0);
      @(negedge clk); chk($sformatf("vec%0d t+1 valid", i), 32'(kpIf.kp_valid), 0);
      @(negedge clk); chk($sformatf("vec%0d valid", i), 32'(kpIf.kp_valid), 32'(vt[i].v));
      if (vt[i].v) chk($sformatf("vec%0d data", i), kpIf.kp_data, vt[i].d);
      kpIf.kp_ready = 1'b1;
      @(posedge clk); #1 kpIf.kp_ready = 1'b0;
      @(negedge clk); chk($sformatf("vec%0d empty", i), 32'(kpIf.kp_valid), 0);
    end

    // Full frame, one keypoint at (5,1), then EOF. Idle samples add nothing.
    do_reset(); thr = 8'd10;
    for (int k = 0; k < 19; k++) begin
      put(k == 0, 1, 0, (k - 3 == 13) ? 20 : 0, 0, 0);
      if (k == 17) begin @(negedge clk); chk("frame t+1 valid", 32'(kpIf.kp_valid), 0); end
      if (k == 18) begin
        @(negedge clk);
        chk("frame t+2 valid", 32'(kpIf.kp_valid), 1);
        chk("frame t+2 data", kpIf.kp_data, mkrec(0, 1, 0, 1, 5, 20));
      end
    end
    for (int k = 0; k < 3; k++) put(0, 1, 100, 0, 0, 0);
    put(0, 0, 0, 0, 0, 0);
    expect_rec("frame kp", mkrec(0, 1, 0, 1, 5, 20));
    expect_rec("frame eof", mkrec(1, 0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    chk("frame idle empty", 32'(kpIf.kp_valid), 0);

    // Overflow: 12 + 8 qualifying samples across a restart, FIFO holds 16.
    do_reset(); thr = 8'd10;
    put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) put(0, 1, 20 + i, 0, 0, 0);
    put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) put(0, 1, 0, 0, 40 + j, 0);
    put(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("ovf count", 32'(ovf_cnt), 4);
    for (int i = 0; i < 12; i++)
      expect_rec($sformatf("ovf recA%0d", i), mkrec(0, 0, 0, i / 8, i % 8, 20 + i));
    for (int j = 0; j < 4; j++)
      expect_rec($sformatf("ovf recB%0d", j), mkrec(0, 2, 0, 0, j, 40 + j));
    repeat (3) @(negedge clk);
    chk("ovf drained", 32'(kpIf.kp_valid), 0);

    // FIFO full at frame end: EOF waits for space; next-frame keypoints drop.
    do_reset(); thr = 8'd10;
    put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
    for (int p = 0; p < 16; p++) put(0, 1, 0, 30 + p, 0, 0);
    put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
    put(0, 1, 50, 0, 0, 0); put(0, 1, 50, 0, 0, 0);
    put(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("full ovf", 32'(ovf_cnt), 2);
    for (int p = 0; p < 16; p++)
      expect_rec($sformatf("full rec%0d", p), mkrec(0, 1, 0, p / 8, p % 8, 30 + p));
    expect_rec("full eof", mkrec(1, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("full drained", 32'(kpIf.kp_valid), 0);

    // sof with en=0, then a sof at pixel (3,0): no EOF for the truncated frame.
    do_reset(); thr = 8'd10;
    put(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) put(0, 1, 0, 0, 0, 0);
    put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
    for (int p = 0; p < 16; p++) put(0, 1, (p == 10) ? 12 : 0, 0, 0, (p == 1) ? -15 : 0);
    put(0, 0, 0, 0, 0, 0);
    expect_rec("restart rec0", mkrec(0, 3, 1, 0, 1, 15));
    expect_rec("restart rec1", mkrec(0, 0, 0, 1, 2, 12));
    expect_rec("restart eof", mkrec(1, 0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    chk("restart drained", 32'(kpIf.kp_valid), 0);

    // Reset mid-operation clears buffered records.
    do_reset(); thr = 8'd10;
    put(1, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0); put(0, 1, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) put(0, 1, 20, 0, 0, 0);
    put(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("prereset valid", 32'(kpIf.kp_valid), 1);
    @(negedge clk); rst_p = 1'b1; #1;
    chk("midreset valid", 32'(kpIf.kp_valid), 0);
    chk("midreset data", kpIf.kp_data, 0);
    #1 rst_p = 1'b0;
    repeat (3) @(negedge clk);
    chk("postreset empty", 32'(kpIf.kp_valid), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/octave_keypoint_collector.md
# octave_keypoint_collector

Consumer of the octave datapath's per-pixel outputs. It takes the en-qualified stream of signed DoG×Harris lanes, compensates the datapath latency to recover pixel coordinates, and thresholds each sample. Qualifying samples are packed into keypoint records and buffered in a FIFO. Records and an end-of-frame marker are delivered over a valid/ready interface to the descriptor or host stage.

## Interface
- outW, 8, width of each signed lane sample
- laneN, 4, number of DoG×Harris lanes (GausTableN-1)
- frameW, 640, samples per line after downsampling
- frameH, 480, lines per frame after downsampling
- PIPE_LAT, 200, en-samples between a pixel entering the octave datapath and its lane result
- FIFO_D, 16, record FIFO depth (power of two)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_p  in  1  asynchronous, active-high reset
- en  in  1  sample strobe; same qualifier as the datapath en_op
- sof  in  1  frame start; the sample in this cycle (if en) is pixel 0 of the datapath input
- laneIn  in  outW*laneN  signed lane samples, lane i at [i*outW+:outW]
- thr  in  outW  unsigned threshold, sampled every cycle
- kp_valid  out  1  record available
- kp_ready  in  1  consumer accepts when high with kp_valid
- kp_data  out  24+outW  record {eof, lane[1:0], sign, y[9:0], x[9:0], mag[outW-1:0]}
- ovf_cnt  out  16  saturating count of dropped records

## Operation
- Score: mag_i = |lane_i|, saturated (−2^(outW-1) → 2^(outW-1)−1). Chosen lane is the max mag_i; ties go to the lowest index. sign = sign bit of the chosen lane.
- Warm-up: on sof, load wcnt=PIPE_LAT and clear x, y. Each en sample decrements wcnt while wcnt≠0; these samples are discarded.
- Once wcnt=0, each en sample is pixel (x,y). x wraps at frameW−1 and increments y. After pixel (frameW−1, frameH−1), counters freeze (idle) until the next sof.
- Qualify: mag > thr (strict) and not in warm-up or idle. Qualifying samples push a record with eof=0.
- EOF: the last pixel sets eof_pending. An EOF record {eof=1, all other fields 0} pushes at the first cycle with FIFO space. It takes priority over any keypoint push that cycle; that keypoint is dropped and counted.
- A new sof while eof_pending keeps the pending marker. Keypoints arriving while eof_pending are dropped and counted.
- A sof mid-frame restarts the counters. No EOF is emitted for the truncated frame.
- Full FIFO: the push is dropped and ovf_cnt increments, saturating at 0xFFFF. Push and pop in the same cycle while full are allowed; the pop frees the slot first.
- sof with en=0 restarts the counters only.

## Timing
- Reset values: kp_valid=0, kp_data=0, ovf_cnt=0, FIFO empty, wcnt=0, idle (no frame active), eof_pending=0.
- Score/qualify stage is registered. A sample at cycle t is written to the FIFO at edge t+1.
- kp_valid rises at t+2 when the FIFO was empty (registered first-word output).
- kp_data is held stable while kp_valid=1 and kp_ready=0.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation clears all state immediately, including FIFO contents.

## Configuration
- KP_NMS_EN defined: 1-D horizontal non-max suppression.
  - Sample n is kept only if score(n) > score(n−1) and score(n) ≥ score(n+1) within the same line. Line edges compare against 0.
  - Adds one en-sample of decision delay; the record still carries the original (x,y).
  - The last pixel of a line is decided at the next en sample, or at EOF.
- KP_NMS_EN undefined: plain per-sample threshold and no extra score registers.

## Structure
- Package sift_kp_pkg: record field offsets and widths (KP_EOF_BIT, KP_LANE_LSB, KP_SIGN_BIT, KP_Y_LSB, KP_X_LSB), function kp_w(outW), and saturating abs function.
- Sub-module kp_fifo: synchronous FIFO, FIFO_D deep, with registered output and full/empty flags. Top level holds counters, scoring, EOF logic and the optional NMS.

## Test plan
- frameW=8, frameH=2, PIPE_LAT=3, thr=10; lane1=+20 at pixel (5,1), all other samples 0 → one record {0,1,0,1,5,20}, then an EOF record; kp_valid rises 2 cycles after the sample.
- Lanes {−128, 127, 0, 0}, thr=100 → lane0 chosen, sign=1, mag=127.
- kp_ready=0 with 20 qualifying samples, FIFO_D=16 → 16 records held, ovf_cnt=4, order preserved on drain.
- FIFO full at frame end; drain one word → EOF record emitted next; keypoints from the next frame during pending are counted in ovf_cnt.
- sof at pixel (3,0) of a running frame → no EOF; the next record coordinates count from the new warm-up.
- KP_NMS_EN, line scores 12,15,15,9, thr=10 → a single record at x=1.
